// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite master types: response codes and master FSM states.
// Error classification is common to the write and read response paths.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_RSP
  } mst_state_e;

  // A single-beat master never asks for exclusive access, so EXOKAY is an error too
  function automatic logic resp_err(input logic [1:0] r);
    logic e;
    e = 1'b1;
    unique case (r)
      RESP_OKAY:   e = 1'b0;
      RESP_EXOKAY,
      RESP_SLVERR,
      RESP_DECERR: e = 1'b1;
      default:     e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/axi_lite_timeout_ctr.sv
// Saturating response-timeout counter for the AXI-Lite master.
// Built only when AXI_LITE_MASTER_TIMEOUT_EN is defined.
module axi_lite_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign expired = (cnt == LAST);

  // Holds at LAST so the budget spans the whole transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/axi_lite_master_if.sv
// Single-outstanding AXI-Lite master behind a valid/ready command port.
// Define AXI_LITE_MASTER_TIMEOUT_EN to build the response timeout.
module axi_lite_master_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_error,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready
);

  import axi_lite_pkg::*;

  localparam int SW = DATA_WIDTH / 8;

  mst_state_e state, nxt;

  logic                  up_q;
  logic                  aw_done, w_done;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]         wstrb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic accept;
  logic aw_hs, w_hs, aw_fin, w_fin;
  logic tmo, tmo_fire;

  assign accept = cmd_valid && cmd_ready;
  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign aw_fin = aw_done || aw_hs;
  assign w_fin  = w_done || w_hs;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  logic cnt_en;

  assign cnt_en = (state == ST_WR_REQ) ||
                  (state == ST_WR_RESP) ||
                  (state == ST_RD_REQ) ||
                  (state == ST_RD_DATA);

  axi_lite_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .en     (cnt_en),
    .expired(tmo)
  );
`else
  logic unused_tmo_cfg;

  assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
  assign tmo            = 1'b0;
`endif

  // Timeout only wins when no handshake would finish the phase anyway
  always_comb begin
    tmo_fire = 1'b0;
    unique case (1'b1)
      state == ST_WR_REQ:  tmo_fire = tmo && !(aw_fin && w_fin);
      state == ST_WR_RESP: tmo_fire = tmo && !bvalid;
      state == ST_RD_REQ:  tmo_fire = tmo && !arready;
      state == ST_RD_DATA: tmo_fire = tmo && !rvalid;
      default:             tmo_fire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) nxt = cmd_write ? ST_WR_REQ : ST_RD_REQ;
      end
      ST_WR_REQ: begin
        if (aw_fin && w_fin) nxt = ST_WR_RESP;
        else if (tmo_fire)   nxt = ST_RSP;
      end
      ST_WR_RESP: begin
        if (bvalid)        nxt = ST_RSP;
        else if (tmo_fire) nxt = ST_RSP;
      end
      ST_RD_REQ: begin
        if (arready)       nxt = ST_RD_DATA;
        else if (tmo_fire) nxt = ST_RSP;
      end
      ST_RD_DATA: begin
        if (rvalid)        nxt = ST_RSP;
        else if (tmo_fire) nxt = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready) nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // cmd_ready stays low during reset and rises one cycle after release
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cmd_ready = up_q;
        busy      = 1'b0;
      end
      ST_WR_REQ: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
      end
      ST_WR_RESP: bready    = 1'b1;
      ST_RD_REQ:  arvalid   = 1'b1;
      ST_RD_DATA: rready    = 1'b1;
      ST_RSP:     rsp_valid = 1'b1;
      default:    busy      = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_q    <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      up_q <= 1'b1;
      if (accept) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (bready && bvalid) begin
        rdata_q <= '0;
        err_q   <= resp_err(bresp);
      end else if (rready && rvalid) begin
        rdata_q <= rdata;
        err_q   <= resp_err(rresp);
      end else if (tmo_fire) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign awprot    = 3'b000;
  assign arprot    = 3'b000;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign rsp_rdata = rdata_q;
  assign rsp_error = err_q;

endmodule

// File: tb/tb_axi_lite_master_if.sv
// Directed bench for axi_lite_master_if with a delay-programmable slave.
// Timeout vectors follow AXI_LITE_MASTER_TIMEOUT_EN.
module tb_axi_lite_master_if;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error, busy;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready, arvalid, arready;
  logic          rvalid, rready;

  always #5 clk = ~clk;

  axi_lite_master_if #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .busy     (busy),
    .awaddr   (awaddr),
    .awprot   (awprot),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wvalid   (wvalid),
    .wready   (wready),
    .bresp    (bresp),
    .bvalid   (bvalid),
    .bready   (bready),
    .araddr   (araddr),
    .arprot   (arprot),
    .arvalid  (arvalid),
    .arready  (arready),
    .rdata    (rdata),
    .rresp    (rresp),
    .rvalid   (rvalid),
    .rready   (rready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  int          aw_dly = 0, w_dly = 0, b_dly = 0;
  int          ar_dly = 0, r_dly = 0;
  logic [1:0]  b_rsp = 2'b00, r_rsp = 2'b00;
  logic [31:0] r_dat = '0;
  int          aw_wt = 0, w_wt = 0, b_wt = 0;
  int          ar_wt = 0, r_wt = 0;
  int          aw_n, w_n, ar_n, aw_hi, w_hi, ar_hi;
  int          aw_cyc, w_cyc, ar_cyc;
  logic [31:0] aw_seen, w_seen, ar_seen;
  logic [3:0]  s_seen;
  logic [2:0]  prot_seen;
  int          ncyc = 0;
  int          c0;

  initial forever begin
    @(posedge clk);
    ncyc++;
  end

  task automatic clr_stats();
    aw_n = 0; w_n = 0; ar_n = 0;
    aw_hi = 0; w_hi = 0; ar_hi = 0;
    aw_cyc = -1; w_cyc = -1; ar_cyc = -1;
    aw_seen = '0; w_seen = '0; ar_seen = '0;
    s_seen = '0; prot_seen = 3'b111;
  endtask

  // Slave reacts on the falling edge; handshakes land on the next rise
  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = 0;
    forever begin
      @(negedge clk);
      if (awvalid) begin
        aw_hi++;
        awready = (aw_wt >= aw_dly);
        aw_wt++;
        if (awready) begin
          aw_n++; aw_cyc = ncyc;
          aw_seen = awaddr; prot_seen = awprot;
        end
      end else begin
        awready = 0; aw_wt = 0;
      end
      if (wvalid) begin
        w_hi++;
        wready = (w_wt >= w_dly);
        w_wt++;
        if (wready) begin
          w_n++; w_cyc = ncyc;
          w_seen = wdata; s_seen = wstrb;
        end
      end else begin
        wready = 0; w_wt = 0;
      end
      if (bready) begin
        bvalid = (b_wt >= b_dly);
        bresp = bvalid ? b_rsp : 2'b00;
        b_wt++;
      end else begin
        bvalid = 0; bresp = 0; b_wt = 0;
      end
      if (arvalid) begin
        ar_hi++;
        arready = (ar_wt >= ar_dly);
        ar_wt++;
        if (arready) begin
          ar_n++; ar_cyc = ncyc;
          ar_seen = araddr; prot_seen = arprot;
        end
      end else begin
        arready = 0; ar_wt = 0;
      end
      if (rready) begin
        rvalid = (r_wt >= r_dly);
        rdata = rvalid ? r_dat : 32'h0;
        rresp = rvalid ? r_rsp : 2'b00;
        r_wt++;
      end else begin
        rvalid = 0; rdata = 0; rresp = 0; r_wt = 0;
      end
    end
  end

  task automatic send(input logic        wr,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0]  s);
    int k;
    k = 0;
    clr_stats();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("cmd_ready_wait", {31'b0, cmd_ready}, 1);
    c0 = ncyc;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      cmd_valid = 1'b0;
      lat++;
    end while (!rsp_valid && lat < 100);
  endtask

  task automatic take(input int hold, output int ok);
    logic [31:0] d0;
    logic        e0;
    d0 = rsp_rdata;
    e0 = rsp_error;
    ok = 1;
    repeat (hold) begin
      @(negedge clk);
      if (!(rsp_valid && !cmd_ready && busy &&
            rsp_rdata == d0 && rsp_error == e0))
        ok = 0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  int lat, ok;

  initial begin
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0;
    cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
    clr_stats();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_valids",
          {26'b0, awvalid, wvalid, bready,
           arvalid, rready, rsp_valid}, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_error", {31'b0, rsp_error}, 0);
    check("rst_awaddr", awaddr, 0);
    check("rst_wdata", wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_cmd_ready", {31'b0, cmd_ready}, 1);

    // zero-wait write
    send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    wait_rsp(lat);
    check("w0_lat", lat, 3);
    check("w0_aw_cyc", aw_cyc - c0, 1);
    check("w0_w_cyc", w_cyc - c0, 1);
    check("w0_awaddr", aw_seen, 32'h10);
    check("w0_wdata", w_seen, 32'hDEADBEEF);
    check("w0_wstrb", {28'b0, s_seen}, 32'hF);
    check("w0_prot", {29'b0, prot_seen}, 0);
    check("w0_err", {31'b0, rsp_error}, 0);
    check("w0_rdata", rsp_rdata, 0);
    check("w0_beats", {aw_n[15:0], w_n[15:0]}, 32'h0001_0001);
    take(0, ok);
    check("w0_b2b_ready", {31'b0, cmd_ready}, 1);
    check("w0_b2b_busy", {31'b0, busy}, 0);

    // awready late by 3, wready immediate
    aw_dly = 3;
    send(1'b1, 32'h20, 32'h12345678, 4'h3);
    wait_rsp(lat);
    check("w1_lat", lat, 6);
    check("w1_aw_cyc", aw_cyc - c0, 4);
    check("w1_w_cyc", w_cyc - c0, 1);
    check("w1_aw_hi", aw_hi, 4);
    check("w1_w_hi", w_hi, 1);
    check("w1_beats", {aw_n[15:0], w_n[15:0]}, 32'h0001_0001);
    check("w1_awaddr", aw_seen, 32'h20);
    check("w1_wdata", w_seen, 32'h12345678);
    check("w1_wstrb", {28'b0, s_seen}, 32'h3);
    check("w1_err", {31'b0, rsp_error}, 0);
    take(0, ok);
    aw_dly = 0;

    // read with 2 wait cycles on R
    r_dly = 2; r_dat = 32'h0000_00A5; r_rsp = 2'b00;
    send(1'b0, 32'h04, 32'h0, 4'h0);
    wait_rsp(lat);
    check("r0_lat", lat, 5);
    check("r0_ar_cyc", ar_cyc - c0, 1);
    check("r0_araddr", ar_seen, 32'h04);
    check("r0_prot", {29'b0, prot_seen}, 0);
    check("r0_rdata", rsp_rdata, 32'hA5);
    check("r0_err", {31'b0, rsp_error}, 0);
    take(0, ok);
    r_dly = 0;

    // SLVERR read, response held off 5 cycles
    r_rsp = 2'b10; r_dat = 32'h55AA1234;
    send(1'b0, 32'h08, 32'h0, 4'h0);
    wait_rsp(lat);
    check("r1_lat", lat, 3);
    check("r1_err", {31'b0, rsp_error}, 1);
    check("r1_rdata", rsp_rdata, 32'h55AA1234);
    take(5, ok);
    check("r1_hold", ok, 1);
    check("r1_b2b_ready", {31'b0, cmd_ready}, 1);

    // EXOKAY write clears rdata, DECERR read
    b_rsp = 2'b01;
    send(1'b1, 32'h0C, 32'h1, 4'h1);
    wait_rsp(lat);
    check("w2_err", {31'b0, rsp_error}, 1);
    check("w2_rdata", rsp_rdata, 0);
    take(0, ok);
    b_rsp = 2'b00;
    r_rsp = 2'b11; r_dat = 32'h0BAD0BAD;
    send(1'b0, 32'h18, 32'h0, 4'h0);
    wait_rsp(lat);
    check("r2_err", {31'b0, rsp_error}, 1);
    check("r2_rdata", rsp_rdata, 32'h0BAD0BAD);
    take(0, ok);
    r_rsp = 2'b00;

    // slave never grants AR
    ar_dly = 1000;
    send(1'b0, 32'h30, 32'h0, 4'h0);
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    wait_rsp(lat);
    check("to_lat", lat, 9);
    check("to_ar_hi", ar_hi, 8);
    check("to_ar_n", ar_n, 0);
    check("to_arvalid", {31'b0, arvalid}, 0);
    check("to_err", {31'b0, rsp_error}, 1);
    check("to_rdata", rsp_rdata, 0);
    take(0, ok);
`else
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("nto_busy", {31'b0, busy}, 1);
    check("nto_arvalid", {31'b0, arvalid}, 1);
    check("nto_ar_n", ar_n, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif
    ar_dly = 0;

    // reset while in WR_REQ
    aw_dly = 5; w_dly = 5;
    send(1'b1, 32'h40, 32'h11112222, 4'hF);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("mr_pre_busy", {31'b0, busy}, 1);
    check("mr_pre_valids", {30'b0, awvalid, wvalid}, 3);
    #2 rst_n = 1'b0;
    #1;
    check("mr_valids", {30'b0, awvalid, wvalid}, 0);
    check("mr_busy", {31'b0, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    aw_dly = 0; w_dly = 0;
    send(1'b1, 32'h44, 32'hCAFEF00D, 4'hF);
    wait_rsp(lat);
    check("mr_w_lat", lat, 3);
    check("mr_w_awaddr", aw_seen, 32'h44);
    check("mr_w_wdata", w_seen, 32'hCAFEF00D);
    check("mr_w_err", {31'b0, rsp_error}, 0);
    take(0, ok);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
